calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_pkg.sv | 52 +++++
 rtl/sseg_scan.sv | 64 ++++++
 rtl/calc_sequencer.sv | 152 +++++++++++++++
 tb/tb_calc_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: FSM state codes, operator
// codes, and the digit-code to seven-segment glyph mapping.
package calc_pkg;

  localparam logic [1:0] ST_LOAD_A = 2'd0;
  localparam logic [1:0] ST_LOAD_B = 2'd1;
  localparam logic [1:0] ST_CALC   = 2'd2;
  localparam logic [1:0] ST_SHOW   = 2'd3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

  typedef logic [4:0] digit_code_t;

  localparam digit_code_t CODE_BLANK = 5'd16;
  localparam digit_code_t CODE_MINUS = 5'd17;

  localparam logic [7:0] GLYPH_BLANK = 8'hFF;
  localparam logic [7:0] GLYPH_MINUS = 8'hBF;

  // Active-low segments, bit0=a .. bit6=g, dp (bit7) always off.
  function automatic logic [7:0] glyph(input digit_code_t code);
    logic [7:0] g;
    g = GLYPH_BLANK;
    if (code == CODE_MINUS) begin
      g = GLYPH_MINUS;
    end else if (!code[4]) begin
      case (code[3:0])
        4'h0: g = 8'hC0;
        4'h1: g = 8'hF9;
        4'h2: g = 8'hA4;
        4'h3: g = 8'hB0;
        4'h4: g = 8'h99;
        4'h5: g = 8'h92;
        4'h6: g = 8'h82;
        4'h7: g = 8'hF8;
        4'h8: g = 8'h80;
        4'h9: g = 8'h90;
        4'hA: g = 8'h88;
        4'hB: g = 8'h83;
        4'hC: g = 8'hC6;
        4'hD: g = 8'hA1;
        4'hE: g = 8'h86;
        4'hF: g = 8'h8E;
        default: g = GLYPH_BLANK;
      endcase
    end
    return g;
  endfunction

endpackage

// File: rtl/sseg_scan.sv
// Four-digit multiplexed seven-segment scanner: dwell counter, digit index,
// anode decode and a registered glyph that changes together with the anodes.
module sseg_scan
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  digit_code_t digit0,
  input  digit_code_t digit1,
  input  digit_code_t digit2,
  input  digit_code_t digit3,
  output logic [7:0]  sseg_o,
  output logic [3:0]  anodes
);

  localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    sseg_q, sseg_d;
  digit_code_t   code_sel;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Glyph is looked up for the index about to become active, so the new
  // segments land on the same edge as the new anode.
  always_comb begin
    code_sel = CODE_BLANK;
    case (idx_d)
      2'd0: code_sel = digit0;
      2'd1: code_sel = digit1;
      2'd2: code_sel = digit2;
      2'd3: code_sel = digit3;
      default: code_sel = CODE_BLANK;
    endcase
    sseg_d = glyph(code_sel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      sseg_q <= GLYPH_BLANK;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      sseg_q <= sseg_d;
    end
  end

  assign anodes = ~(4'b0001 << idx_q);
  assign sseg_o = sseg_q;

endmodule

// File: rtl/calc_sequencer.sv
// Two-operand switch calculator: synchronized inputs, LOAD_A/LOAD_B/CALC/SHOW
// sequencing, unsigned arithmetic, and display content for the scanner.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] number,
  input  logic [1:0] op_sel,
  input  logic       enter,
  output logic [7:0] sseg_o,
  output logic [3:0] anodes
);

  logic       enter_s1_q, enter_s2_q, enter_prev_q;
  logic [3:0] num_s1_q, num_s2_q;
  logic [1:0] op_s1_q, op_s2_q;
  logic       enter_p;

  logic [1:0] state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [1:0] op_q, op_d;
  logic [7:0] r_q, r_d;
  logic       neg_q, neg_d;

  logic [7:0] calc_r;
  logic       calc_neg;

  digit_code_t dig0, dig1, dig2, dig3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enter_s1_q   <= 1'b0;
      enter_s2_q   <= 1'b0;
      enter_prev_q <= 1'b0;
      num_s1_q     <= '0;
      num_s2_q     <= '0;
      op_s1_q      <= '0;
      op_s2_q      <= '0;
    end else begin
      enter_s1_q   <= enter;
      enter_s2_q   <= enter_s1_q;
      enter_prev_q <= enter_s2_q;
      num_s1_q     <= number;
      num_s2_q     <= num_s1_q;
      op_s1_q      <= op_sel;
      op_s2_q      <= op_s1_q;
    end
  end

  assign enter_p = enter_s2_q & ~enter_prev_q;

  always_comb begin
    calc_neg = 1'b0;
    case (op_q)
      OP_SUB: begin
        if (a_q >= b_q) begin
          calc_r = {4'h0, a_q - b_q};
        end else begin
          calc_r   = {4'h0, b_q - a_q};
          calc_neg = 1'b1;
        end
      end
      OP_MUL:  calc_r = {4'h0, a_q} * {4'h0, b_q};
      default: calc_r = {4'h0, a_q} + {4'h0, b_q};
    endcase
  end

  // CALC always advances; a press landing there is simply not looked at.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    r_d     = r_q;
    neg_d   = neg_q;
    case (state_q)
      ST_LOAD_A: begin
        if (enter_p) begin
          a_d     = num_s2_q;
          op_d    = op_s2_q;
          state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        if (enter_p) begin
          b_d     = num_s2_q;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        r_d     = calc_r;
        neg_d   = calc_neg;
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (enter_p) state_d = ST_LOAD_A;
      end
      default: state_d = ST_LOAD_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      r_q     <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      r_q     <= r_d;
      neg_q   <= neg_d;
    end
  end

  always_comb begin
    dig0 = {1'b0, num_s2_q};
    dig1 = CODE_BLANK;
    dig2 = CODE_BLANK;
    dig3 = CODE_BLANK;
    case (state_q)
      ST_LOAD_B, ST_CALC: dig3 = {1'b0, a_q};
      ST_SHOW: begin
        dig0 = {1'b0, r_q[3:0]};
        dig1 = {1'b0, r_q[7:4]};
        dig3 = neg_q ? CODE_MINUS : CODE_BLANK;
      end
      default: ;
    endcase
  end

  sseg_scan #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .digit0 (dig0),
    .digit1 (dig1),
    .digit2 (dig2),
    .digit3 (dig3),
    .sseg_o (sseg_o),
    .anodes (anodes)
  );

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomized and directed bench for calc_sequencer against a behavioural
// model of the calculator's visible display.
module tb_calc_sequencer;

  localparam int unsigned SCAN_DIV = 4;

  localparam logic [7:0] G [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic       clk, rst, enter;
  logic [3:0] number;
  logic [1:0] op_sel;
  logic [7:0] sseg_o;
  logic [3:0] anodes;

  calc_sequencer #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .number (number),
    .op_sel (op_sel),
    .enter  (enter),
    .sseg_o (sseg_o),
    .anodes (anodes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 = entering A, 1 = entering B, 2 = showing result.
  int unsigned mode = 0;
  logic [3:0]  ma = '0, mb = '0, live = '0;
  logic [1:0]  mop = '0;
  bit          chk_en = 0;
  int unsigned cyc;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_glyph(input int unsigned d);
    int unsigned ri;
    logic [7:0]  r;
    bit          ng;
    if (mop == 2'd1)      ri = (ma >= mb) ? ma - mb : mb - ma;
    else if (mop == 2'd2) ri = ma * mb;
    else                  ri = ma + mb;
    r  = ri[7:0];
    ng = (mop == 2'd1) && (ma < mb);
    case (mode)
      0: return (d == 0) ? G[live] : 8'hFF;
      1: return (d == 0) ? G[live] : (d == 3) ? G[ma] : 8'hFF;
      default: begin
        if (d == 0) return G[r[3:0]];
        if (d == 1) return G[r[7:4]];
        if (d == 3) return ng ? 8'hBF : 8'hFF;
        return 8'hFF;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    int unsigned idx;
    logic [3:0]  exp_an;
    if (!rst) begin
      idx    = (cyc / SCAN_DIV) % 4;
      exp_an = ~(4'b0001 << idx);
      check("anodes_scan", {4'h0, anodes}, {4'h0, exp_an});
      if (chk_en) check("sseg_model", sseg_o, model_glyph(idx));
    end
  end

  task automatic expect_digit(input int unsigned d, input logic [7:0] exp, input string name);
    logic [3:0] want;
    int k;
    want = ~(4'b0001 << d);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (anodes !== want && k < 40);
    if (anodes !== want) check({name, "_timeout"}, {4'h0, anodes}, {4'h0, want});
    else                 check(name, sseg_o, exp);
  endtask

  task automatic set_num(input logic [3:0] v, input logic [1:0] op);
    chk_en = 0;
    @(negedge clk);
    number = v;
    op_sel = op;
    live   = v;
    repeat (4) @(negedge clk);
    chk_en = 1;
  endtask

  task automatic enter_step(input int hold);
    chk_en = 0;
    @(negedge clk);
    enter = 1'b1;
    repeat (hold) @(negedge clk);
    enter = 1'b0;
    repeat (6) @(negedge clk);
    if (mode == 0) begin
      ma = live; mop = op_sel; mode = 1;
    end else if (mode == 1) begin
      mb = live; mode = 2;
    end else begin
      mode = 0;
    end
    chk_en = 1;
  endtask

  task automatic model_reset();
    mode = 0; ma = '0; mb = '0; mop = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enter = 1'b0; number = '0; op_sel = '0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (6) @(negedge clk);

    // Mid-cycle asynchronous reset, then the scan sequence from index 0.
    @(posedge clk);
    #3 rst = 1'b1;
    model_reset();
    #1;
    check("rst_anodes", {4'h0, anodes}, 8'h0E);
    check("rst_sseg", sseg_o, 8'hFF);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    check("scan_1101", {4'h0, anodes}, 8'h0D);
    repeat (4) @(negedge clk);
    check("scan_1011", {4'h0, anodes}, 8'h0B);
    repeat (4) @(negedge clk);
    check("scan_0111", {4'h0, anodes}, 8'h07);
    repeat (4) @(negedge clk);
    check("scan_1110", {4'h0, anodes}, 8'h0E);
    chk_en = 1;

    // 3 + 5
    set_num(4'd3, 2'b00); enter_step(2);
    set_num(4'd5, 2'b00); enter_step(1);
    expect_digit(0, 8'h80, "add_d0");
    expect_digit(1, 8'hC0, "add_d1");
    expect_digit(3, 8'hFF, "add_d3");
    enter_step(1);

    // 2 - 7
    set_num(4'd2, 2'b01); enter_step(1);
    set_num(4'd7, 2'b01); enter_step(3);
    expect_digit(0, 8'h92, "sub_d0");
    expect_digit(1, 8'hC0, "sub_d1");
    expect_digit(3, 8'hBF, "sub_d3");
    enter_step(1);

    // F * F
    set_num(4'hF, 2'b10); enter_step(1);
    set_num(4'hF, 2'b10); enter_step(1);
    expect_digit(0, 8'hF9, "mul_d0");
    expect_digit(1, 8'h86, "mul_d1");
    expect_digit(3, 8'hFF, "mul_d3");
    enter_step(1);

    // Long press gives a single advance to LOAD_B.
    set_num(4'd6, 2'b00); enter_step(50);
    repeat (30) @(negedge clk);
    expect_digit(3, 8'h82, "hold_d3");
    set_num(4'd1, 2'b00);
    expect_digit(3, 8'h82, "hold_still_lb");
    enter_step(1);
    expect_digit(0, 8'hF8, "hold_sum");
    enter_step(1);

    // Reset in LOAD_B discards A.
    set_num(4'd9, 2'b00); enter_step(1);
    expect_digit(3, 8'h90, "lb_a9");
    chk_en = 0;
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_en = 1;
    expect_digit(3, 8'hFF, "rst_lb_d3");
    expect_digit(0, 8'h90, "rst_lb_live");
    set_num(4'd4, 2'b00); enter_step(1);
    expect_digit(3, 8'h99, "rst_new_a");
    set_num(4'd0, 2'b00); enter_step(1);
    expect_digit(0, 8'h99, "rst_new_sum");
    enter_step(1);

    // Randomized operand/operator sequences, including op 11.
    for (int i = 0; i < 25; i++) begin
      logic [3:0] a, b;
      logic [1:0] op;
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      op = 2'($urandom_range(0, 3));
      set_num(a, op);
      repeat (8) @(negedge clk);
      enter_step(int'($urandom_range(1, 4)));
      set_num(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      repeat (17) @(negedge clk);
      set_num(b, op_sel);
      enter_step(int'($urandom_range(1, 4)));
      repeat (20) @(negedge clk);
      enter_step(1);
      repeat (8) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
